// File: rtl/gsel_unlock_ctrl.sv
// Write-decode stage feeding the PROG CPLD mapper: tracks P2_BANK and a key-protected
// GSEL register, and reports each committed GSEL to the cart MCU over req/ack.
module gsel_unlock_ctrl #(
    parameter logic [7:0]  KEY0        = 8'hA5,
    parameter logic [7:0]  KEY1        = 8'h5A,
    parameter logic [7:0]  KEY2        = 8'hC3,
    parameter logic [18:0] MAGIC_ADDR  = 19'h607F7,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [18:0] M68K_ADDR,
    input  logic [7:0]  M68K_DATA,
    input  logic        nPORTWEL,
    input  logic [2:0]  BANKS,
    output logic [7:0]  GSEL,
    output logic [2:0]  P2_BANK,
    output logic        LOCKED,
    output logic        MCU_REQ,
    output logic [7:0]  MCU_DATA,
    input  logic        MCU_ACK
);

    typedef enum logic [2:0] {IDLE, S1, S2, ARMED, NOTIFY, ACKWAIT} state_t;

    state_t      state, state_nxt;
    logic        pwel_s1, pwel_s2, pwel_d;
    logic        ack_s1, ack_s2;
    logic [18:0] hold_addr;
    logic [7:0]  hold_data;
    logic [15:0] tcnt;
    logic        wev, magic_wev, p2_wev, running, expire, commit;

    // Synchronizers idle at the bus-inactive level so reset release never fakes an edge
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pwel_s1   <= 1'b1;
            pwel_s2   <= 1'b1;
            pwel_d    <= 1'b1;
            ack_s1    <= 1'b0;
            ack_s2    <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            pwel_s1 <= nPORTWEL;
            pwel_s2 <= pwel_s1;
            pwel_d  <= pwel_s2;
            ack_s1  <= MCU_ACK;
            ack_s2  <= ack_s1;
            if (pwel_d && !pwel_s2) begin
                hold_addr <= M68K_ADDR;
                hold_data <= M68K_DATA;
            end
        end
    end

    assign wev       = !pwel_d && pwel_s2;
    assign magic_wev = wev && (hold_addr == MAGIC_ADDR);
    assign p2_wev    = wev && (hold_addr != MAGIC_ADDR);
    assign running   = (state == S1) || (state == S2) || (state == ARMED);
    assign expire    = running && (tcnt == TIMEOUT_CYC - 16'd1);
    assign commit    = (state == ARMED) && magic_wev;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    // A magic write in the expiry cycle is evaluated before the timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (magic_wev && hold_data == KEY0) state_nxt = S1;
            S1: begin
                if (magic_wev)
                    state_nxt = (hold_data == KEY1) ? S2 : (hold_data == KEY0) ? S1 : IDLE;
                else if (expire)
                    state_nxt = IDLE;
            end
            S2: begin
                if (magic_wev)
                    state_nxt = (hold_data == KEY2) ? ARMED : (hold_data == KEY0) ? S1 : IDLE;
                else if (expire)
                    state_nxt = IDLE;
            end
            ARMED: begin
                if (magic_wev)   state_nxt = NOTIFY;
                else if (expire) state_nxt = IDLE;
            end
            NOTIFY:  if (ack_s2)  state_nxt = ACKWAIT;
            ACKWAIT: if (!ack_s2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        LOCKED = !running;
    end

    // Saturating inter-write timer; held at zero outside the unlock states
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)                         tcnt <= '0;
        else if (!running || magic_wev)      tcnt <= '0;
        else if (tcnt != TIMEOUT_CYC - 16'd1) tcnt <= tcnt + 16'd1;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            GSEL     <= '0;
            P2_BANK  <= '0;
            MCU_REQ  <= 1'b0;
            MCU_DATA <= '0;
        end else begin
            if (commit) begin
                GSEL     <= hold_data;
                MCU_DATA <= hold_data;
                P2_BANK  <= '0;
                MCU_REQ  <= 1'b1;
            end else if (p2_wev) begin
                P2_BANK <= (hold_data[2:0] <= BANKS) ? hold_data[2:0] : 3'd0;
            end
            if (state == NOTIFY && ack_s2) MCU_REQ <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gsel_unlock_ctrl.sv
// Scoreboard bench for gsel_unlock_ctrl: expected outputs queued per stimulus step and
// compared once the synchronized write or handshake has settled.
module tb_gsel_unlock_ctrl;

    localparam logic [18:0] MA = 19'h607F7;
    localparam logic [18:0] NA = 19'h00100;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic [18:0] M68K_ADDR;
    logic [7:0]  M68K_DATA;
    logic        nPORTWEL;
    logic [2:0]  BANKS;
    logic [7:0]  GSEL;
    logic [2:0]  P2_BANK;
    logic        LOCKED;
    logic        MCU_REQ;
    logic [7:0]  MCU_DATA;
    logic        MCU_ACK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] gsel;
        logic [2:0] p2;
        logic       req;
        logic       locked;
    } exp_t;
    exp_t sb[$];

    gsel_unlock_ctrl dut (
        .CLK(CLK), .nRESET(nRESET), .M68K_ADDR(M68K_ADDR), .M68K_DATA(M68K_DATA),
        .nPORTWEL(nPORTWEL), .BANKS(BANKS), .GSEL(GSEL), .P2_BANK(P2_BANK),
        .LOCKED(LOCKED), .MCU_REQ(MCU_REQ), .MCU_DATA(MCU_DATA), .MCU_ACK(MCU_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({tag, " gsel"},   {24'd0, GSEL},     {24'd0, e.gsel});
        chk({tag, " p2"},     {29'd0, P2_BANK},  {29'd0, e.p2});
        chk({tag, " req"},    {31'd0, MCU_REQ},  {31'd0, e.req});
        chk({tag, " mdata"},  {24'd0, MCU_DATA}, {24'd0, e.gsel});
        chk({tag, " locked"}, {31'd0, LOCKED},   {31'd0, e.locked});
    endtask

    // Low pulse of 4 CLK, then 4 CLK of settle: past the 3-cycle commit latency
    task automatic wr(input logic [18:0] a, input logic [7:0] d, input logic [7:0] g,
                      input logic [2:0] p, input logic r, input logic l);
        sb.push_back('{g, p, r, l});
        M68K_ADDR = a;
        M68K_DATA = d;
        nPORTWEL  = 1'b0;
        repeat (4) @(negedge CLK);
        nPORTWEL = 1'b1;
        repeat (4) @(negedge CLK);
        sb_pop($sformatf("wr %h:%h", a, d));
    endtask

    task automatic ack(input logic [7:0] g, input logic [2:0] p);
        sb.push_back('{g, p, 1'b0, 1'b1});
        MCU_ACK = 1'b1;
        repeat (4) @(negedge CLK);
        sb_pop("ack_hi");
        sb.push_back('{g, p, 1'b0, 1'b1});
        MCU_ACK = 1'b0;
        repeat (4) @(negedge CLK);
        sb_pop("ack_lo");
    endtask

    task automatic rst_async(input string tag);
        sb.push_back('{8'h00, 3'd0, 1'b0, 1'b1});
        #2;
        nRESET = 1'b0;
        #1;
        sb_pop(tag);
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic chk_locked(input string tag, input logic l);
        chk(tag, {31'd0, LOCKED}, {31'd0, l});
    endtask

    initial begin
        nRESET = 1'b0; M68K_ADDR = '0; M68K_DATA = '0; nPORTWEL = 1'b1;
        BANKS = 3'd3; MCU_ACK = 1'b0;
        repeat (3) @(negedge CLK);
        sb.push_back('{8'h00, 3'd0, 1'b0, 1'b1});
        sb_pop("reset");
        nRESET = 1'b1;
        @(negedge CLK);

        // basic unlock + commit + handshake
        wr(MA, 8'hA5, 8'h00, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'h5A, 8'h00, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'hC3, 8'h00, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'h07, 8'h07, 3'd0, 1'b1, 1'b1);
        ack(8'h07, 3'd0);

        // P2 bank clamp against BANKS
        wr(NA, 8'h02, 8'h07, 3'd2, 1'b0, 1'b1);
        wr(NA, 8'h05, 8'h07, 3'd0, 1'b0, 1'b1);
        wr(NA, 8'h03, 8'h07, 3'd3, 1'b0, 1'b1);

        // wrong third key aborts; repeated KEY0 restarts
        wr(MA, 8'hA5, 8'h07, 3'd3, 1'b0, 1'b0);
        wr(MA, 8'h5A, 8'h07, 3'd3, 1'b0, 1'b0);
        wr(MA, 8'h11, 8'h07, 3'd3, 1'b0, 1'b1);
        wr(MA, 8'hA5, 8'h07, 3'd3, 1'b0, 1'b0);
        wr(MA, 8'hA5, 8'h07, 3'd3, 1'b0, 1'b0);
        wr(NA, 8'h01, 8'h07, 3'd1, 1'b0, 1'b0);
        wr(MA, 8'h5A, 8'h07, 3'd1, 1'b0, 1'b0);
        wr(MA, 8'hC3, 8'h07, 3'd1, 1'b0, 1'b0);
        wr(MA, 8'h09, 8'h09, 3'd0, 1'b1, 1'b1);
        ack(8'h09, 3'd0);

        // timeout: full TIMEOUT_CYC gap aborts
        wr(MA, 8'hA5, 8'h09, 3'd0, 1'b0, 1'b0);
        repeat (4096) @(negedge CLK);
        chk_locked("timeout_expired", 1'b1);
        wr(MA, 8'h5A, 8'h09, 3'd0, 1'b0, 1'b1);
        wr(MA, 8'hC3, 8'h09, 3'd0, 1'b0, 1'b1);
        wr(MA, 8'h09, 8'h09, 3'd0, 1'b0, 1'b1);

        // one cycle late: write lands just after expiry, sequence lost
        wr(MA, 8'hA5, 8'h09, 3'd0, 1'b0, 1'b0);
        repeat (4089) @(negedge CLK);
        wr(MA, 8'h5A, 8'h09, 3'd0, 1'b0, 1'b1);

        // next write event lands exactly on the expiry cycle and wins
        wr(MA, 8'hA5, 8'h09, 3'd0, 1'b0, 1'b0);
        repeat (4088) @(negedge CLK);
        chk_locked("pre_expiry", 1'b0);
        wr(MA, 8'h5A, 8'h09, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'hC3, 8'h09, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'h0B, 8'h0B, 3'd0, 1'b1, 1'b1);
        ack(8'h0B, 3'd0);

        // full sequence during NOTIFY is ignored; P2 writes still land
        wr(MA, 8'hA5, 8'h0B, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'h5A, 8'h0B, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'hC3, 8'h0B, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'h21, 8'h21, 3'd0, 1'b1, 1'b1);
        wr(MA, 8'hA5, 8'h21, 3'd0, 1'b1, 1'b1);
        wr(MA, 8'h5A, 8'h21, 3'd0, 1'b1, 1'b1);
        wr(NA, 8'h01, 8'h21, 3'd1, 1'b1, 1'b1);
        wr(MA, 8'hC3, 8'h21, 3'd1, 1'b1, 1'b1);
        wr(MA, 8'h33, 8'h21, 3'd1, 1'b1, 1'b1);
        ack(8'h21, 3'd1);

        // async reset in S2 loses the half-entered key
        wr(MA, 8'hA5, 8'h21, 3'd1, 1'b0, 1'b0);
        wr(MA, 8'h5A, 8'h21, 3'd1, 1'b0, 1'b0);
        rst_async("rst_in_s2");
        wr(MA, 8'hC3, 8'h00, 3'd0, 1'b0, 1'b1);
        wr(MA, 8'h55, 8'h00, 3'd0, 1'b0, 1'b1);

        // async reset in NOTIFY
        wr(MA, 8'hA5, 8'h00, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'h5A, 8'h00, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'hC3, 8'h00, 3'd0, 1'b0, 1'b0);
        wr(MA, 8'h44, 8'h44, 3'd0, 1'b1, 1'b1);
        rst_async("rst_in_notify");
        wr(NA, 8'h02, 8'h00, 3'd2, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gsel_unlock_ctrl.md
Name: gsel_unlock_ctrl

Overview:
- Clocked write-decode stage directly upstream of the PROG CPLD flash-address mapper.
- Watches 68K port writes and maintains P2_BANK and the game-select byte GSEL that the mapper consumes.
- GSEL changes only after a keyed unlock sequence, so stray writes to the magic address cannot switch games.
- Each committed GSEL is reported to the cart MCU over a req/ack handshake.

Parameters:
- KEY0, 8'hA5, first unlock byte
- KEY1, 8'h5A, second unlock byte
- KEY2, 8'hC3, third unlock byte
- MAGIC_ADDR, 19'h607F7, word address (68K byte 0x2C0FEE) of the key/GSEL register
- TIMEOUT_CYC, 16'd4096, CLK cycles allowed between sequence writes before abort

Ports:
- CLK  in  1  free-running clock, at least 3x faster than the shortest nPORTWEL low pulse
- nRESET  in  1  reset
- M68K_ADDR  in  19  68K word address [19:1]
- M68K_DATA  in  8  68K data [7:0]
- nPORTWEL  in  1  port write strobe, low byte, active-low
- BANKS  in  3  highest legal P2 bank for the current GSEL, from the mapper decode
- GSEL  out  8  committed game select
- P2_BANK  out  3  committed P2 bank
- LOCKED  out  1  high when no unlock sequence is in progress
- MCU_REQ  out  1  new-GSEL request to the MCU
- MCU_DATA  out  8  GSEL value presented with MCU_REQ
- MCU_ACK  in  1  MCU acknowledge, asynchronous

Behaviour:
- Reset is nRESET, asynchronous, active-low. While low:
  - GSEL = 0, P2_BANK = 0, MCU_REQ = 0, MCU_DATA = 0
  - LOCKED = 1, FSM = IDLE, timeout counter = 0
  - synchronizers preset to the idle level (nPORTWEL = 1, MCU_ACK = 0)
- Synchronization:
  - nPORTWEL and MCU_ACK each pass through a 2-FF synchronizer.
  - Falling edge of synced nPORTWEL: capture M68K_ADDR and M68K_DATA into holding registers.
  - Rising edge of synced nPORTWEL: one-cycle write event (WEV) using the held values.
  - A low pulse of at least 3 CLK cycles is required. Commit latency is 1 CLK after the synced rising edge, i.e. 3 CLK after the pin rises.
- Non-magic write (WEV with held addr != MAGIC_ADDR):
  - P2_BANK <= (data[2:0] <= BANKS) ? data[2:0] : 0
  - Accepted in every FSM state.
  - Does not advance, abort or time out the unlock sequence.
- FSM, driven by magic writes (WEV with addr == MAGIC_ADDR):
  - IDLE: data == KEY0 -> S1; otherwise stay in IDLE.
  - S1: data == KEY1 -> S2; data == KEY0 -> S1; otherwise -> IDLE.
  - S2: data == KEY2 -> ARMED; data == KEY0 -> S1; otherwise -> IDLE.
  - ARMED: any data commits:
    - GSEL <= data, MCU_DATA <= data, P2_BANK <= 0, MCU_REQ <= 1
    - go to NOTIFY
  - NOTIFY: magic writes are ignored. Synced MCU_ACK = 1 -> MCU_REQ <= 0, go to ACKWAIT.
  - ACKWAIT: magic writes are ignored. Synced MCU_ACK = 0 -> IDLE.
- LOCKED = 1 in IDLE, NOTIFY and ACKWAIT; LOCKED = 0 in S1, S2 and ARMED.
- Timeout:
  - The 16-bit counter runs only in S1, S2 and ARMED, and clears on every magic write event.
  - When the count reaches TIMEOUT_CYC-1 the FSM goes to IDLE.
  - If a magic write event and expiry occur in the same cycle, the write wins.
  - The counter never wraps.
- MCU_DATA and GSEL are stable while MCU_REQ = 1.
- An MCU_ACK already high when NOTIFY is entered is accepted on the next cycle.
- Reset mid-sequence or mid-handshake returns all state to reset values. A half-entered key is lost.

Test Plan:
- Reset, then writes to 0x2C0FEE of A5, 5A, C3, 07 -> GSEL = 07, P2_BANK = 0, MCU_REQ = 1, MCU_DATA = 07; MCU_ACK pulse -> MCU_REQ = 0, LOCKED = 1.
- BANKS = 3; non-magic writes of 02 then 05 -> P2_BANK = 2, then 0.
- A5, 5A, then 11 to magic address -> back to IDLE, GSEL unchanged. Then A5, A5, 5A, C3, 09 -> GSEL = 09 (KEY0 restarts the sequence).
- A5, then an idle gap of TIMEOUT_CYC cycles, then 5A, C3, 09 -> no commit, GSEL unchanged. Repeat with the next write landing on the expiry cycle -> sequence continues.
- Commit, then a new full sequence while in NOTIFY -> ignored, GSEL unchanged. Interleaved P2 write 01 in NOTIFY -> P2_BANK = 1.
- Assert nRESET while in S2 and while in NOTIFY -> all outputs return to reset values, asynchronously.
